ffo32_decoder_seq: RTL and testbench
====================================

FFO32_DECODER_SEQ -- requirements
Module: ffo32_decoder_seq

Interface
REQ-001 The module SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Parameter N, default 32, SHALL be the output vector width; it SHALL be a power of two, at least 2.
REQ-003 Derived constant LOG2N, default $clog2(N) = 5, SHALL be the position width and the number of decode levels.
REQ-004 Port clock, input, 1 bit: rising-edge clock.
REQ-005 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-006 Port start, input, 1 bit: request; sampled only while ready=1.
REQ-007 Port v, input, 1 bit: position-valid flag (1 = a one exists).
REQ-008 Port p, input, LOG2N bits, indexed [0:LOG2N-1] with p[0] as MSB: position of the first one, counted from the left.
REQ-009 Port ready, output, 1 bit: module is idle and accepts start.
REQ-010 Port done, output, 1 bit: one-cycle pulse; b holds the new result.
REQ-011 Port b, output, N bits, indexed [0:N-1] with b[0] leftmost: decoded one-hot vector.

Function
REQ-012 The module SHALL be the inverse of the find-first-one encoder: for v=1 it SHALL drive b with exactly one bit set, at index b[p]; for v=0 it SHALL drive b to all zeros.
REQ-013 The FSM SHALL have three states: IDLE, LEVEL and DONE, plus a LOG2N-wide level counter lvl.
REQ-014 IDLE: ready=1; on a rising edge with start=1, p and v SHALL be captured, window mask m set to all ones, lvl set to 0, and the FSM SHALL move to LEVEL.
REQ-015 LEVEL: each edge SHALL narrow m to its left half if p[lvl]=0 or its right half if p[lvl]=1, with half size N>>(lvl+1), then increment lvl.
REQ-016 When LEVEL processes lvl=LOG2N-1, the next state SHALL be DONE.
REQ-017 DONE: for exactly one cycle, done=1, ready=0 and b=(v ? m : 0); the next state SHALL be IDLE.
REQ-018 Latency: if start is sampled at edge T, done SHALL be high in the cycle after edge T+LOG2N (T+5 for N=32).
REQ-019 Throughput: one operation per LOG2N+2 cycles; after DONE the FSM SHALL spend at least one cycle in IDLE.
REQ-020 start SHALL be ignored in LEVEL and DONE, and changes to p or v after capture SHALL have no effect.
REQ-021 b SHALL be registered, SHALL update only on entry to DONE, and SHALL hold its value until the next DONE.
REQ-022 ready SHALL be high only in IDLE; done SHALL be high only in DONE.

Reset
REQ-023 While reset=1: state=IDLE, lvl=0, m=all ones, b=0, done=0, ready=1.
REQ-024 Reset asserted mid-operation SHALL abort the operation: no done pulse and b=0.
REQ-025 After reset is released, the first start SHALL be accepted on the first rising edge.

Structure
REQ-026 Package ffo_pkg SHALL hold the N and LOG2N defaults, the state enum (IDLE, LEVEL, DONE), and a function half_mask(lvl, sel) that returns the N-bit half-window mask.
REQ-027 The block SHALL be a single module with no sub-modules; the level step SHALL be the half_mask function.

Verification
REQ-028 v=1, p=0, start pulse -> done after 5 cycles, b=32'h8000_0000, ready high one cycle later.
REQ-029 v=1, p=31 -> b=32'h0000_0001; v=1, p=13 -> b=32'h0004_0000.
REQ-030 v=0, p=7 -> done pulses, b=32'h0000_0000.
REQ-031 start held high continuously with p changed during LEVEL -> result reflects the captured p, and ops are accepted every 7 cycles.
REQ-032 reset asserted at lvl=2 -> ready=1, done never pulses, b=0; a later op completes correctly.
REQ-033 Round trip: sweep p=0..31 with v=1, feed each b into the combinational FFO32 -> FFO32 returns the same p with v=1; all other b bits are zero.

Source files
------------

// File: rtl/ffo_pkg.sv
// Shared definitions for the sequential one-hot decoder: default sizes, FSM states
// and the per-level window-halving mask.
package ffo_pkg;

    localparam int N_DEF     = 32;
    localparam int LOG2N_DEF = $clog2(N_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEVEL = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Periodic mask selecting the left (sel=0) or right (sel=1) half of every
    // window of size N>>lvl; ANDing it with the current window narrows it.
    function automatic logic [0:N_DEF-1] half_mask(input logic [LOG2N_DEF-1:0] lvl,
                                                   input logic                 sel);
        logic [0:N_DEF-1] hm;
        int               sh;
        sh = LOG2N_DEF - 1 - int'(lvl);
        for (int i = 0; i < N_DEF; i++) begin
            hm[i] = (((i >> sh) & 1) == int'(sel));
        end
        return hm;
    endfunction

endpackage

// File: rtl/ffo32_decoder_seq.sv
// Sequential inverse of a find-first-one encoder: turns (v, p) into a one-hot vector
// by halving an all-ones window once per position bit, MSB first.
module ffo32_decoder_seq
    import ffo_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      v,
    input  logic [0:$clog2(N)-1]      p,
    output logic                      ready,
    output logic                      done,
    output logic [0:N-1]              b
);

    localparam int                LOG2N    = $clog2(N);
    localparam int                LVLW     = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam logic [LOG2N-1:0]  LVL_LAST = LOG2N'(LOG2N - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [0:LOG2N-1]   r_p;
    logic               r_v;
    logic [0:N-1]       r_m;
    logic [LOG2N-1:0]   r_lvl;
    logic [0:N-1]       r_b;
    logic               w_sel;
    logic               w_last;
    logic [0:N-1]       w_m_nxt;

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        done        = 1'b0;
        w_sel       = r_p[r_lvl[LVLW-1:0]];
        w_last      = (r_lvl == LVL_LAST);
        w_m_nxt     = r_m & half_mask(r_lvl, w_sel);
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = LEVEL;
                end
            end
            LEVEL: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The level counter stops at the last level so r_p is never indexed out of range.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_p     <= '0;
            r_v     <= 1'b0;
            r_m     <= '1;
            r_lvl   <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_p   <= p;
                        r_v   <= v;
                        r_m   <= '1;
                        r_lvl <= '0;
                    end
                end
                LEVEL: begin
                    r_m <= w_m_nxt;
                    if (w_last) begin
                        r_b <= r_v ? w_m_nxt : '0;
                    end else begin
                        r_lvl <= r_lvl + LOG2N'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign b = r_b;

endmodule

// File: tb/tb_ffo32_decoder_seq.sv
// Self-checking bench for ffo32_decoder_seq against a one-hot reference model.
module tb_ffo32_decoder_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        v;
    logic [0:4]  p;
    logic        ready;
    logic        done;
    logic [0:31] b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    ffo32_decoder_seq #(.N(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .v     (v),
        .p     (p),
        .ready (ready),
        .done  (done),
        .b     (b)
    );

    function automatic logic [0:31] model(input logic [4:0] pp, input logic vv);
        logic [0:31] r;
        r = '0;
        if (vv) r[pp] = 1'b1;
        return r;
    endfunction

    // Combinational find-first-one from the left, used for the round trip.
    function automatic void ffo32(input logic [0:31] x, output logic [4:0] pos, output logic vld);
        pos = '0;
        vld = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) begin
                pos = 5'(i);
                vld = 1'b1;
            end
        end
    endfunction

    task automatic run_op(input logic [4:0] pp, input logic vv, input bit scramble,
                          input bit no_wait, output logic [0:31] bo, output int lat,
                          output logic rdy_after, output logic done_after);
        if (!no_wait) @(negedge clock);
        start = 1'b1;
        p     = pp;
        v     = vv;
        @(posedge clock);
        lat = -1;
        bo  = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 1) begin
                start = 1'b0;
                if (scramble) begin
                    p = 5'($urandom);
                    v = 1'($urandom);
                end
            end
            if (done === 1'b1) begin
                lat = k;
                bo  = b;
                break;
            end
        end
        @(negedge clock);
        rdy_after  = ready;
        done_after = done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        p     = '0;
        v     = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_tests++;
        if (b !== 32'h0) begin n_fail++; $display("FAIL reset_b got=%h exp=0", b); end
        start = 1'b1;
        @(negedge clock);
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ignored ready got=%b exp=1", ready); end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_corners();
        logic [4:0]  cp [4] = '{5'd0, 5'd31, 5'd13, 5'd7};
        logic        cv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] cb [4] = '{32'h8000_0000, 32'h0000_0001, 32'h0004_0000, 32'h0000_0000};
        logic [0:31] bo;
        int          lat;
        logic        ra, da;
        for (int i = 0; i < 4; i++) begin
            run_op(cp[i], cv[i], 1'b0, 1'b0, bo, lat, ra, da);
            n_tests++;
            if (bo !== cb[i]) begin n_fail++; $display("FAIL corner_b[%0d] got=%h exp=%h", i, bo, cb[i]); end
            n_tests++;
            if (lat !== 6) begin n_fail++; $display("FAIL corner_latency[%0d] got=%0d exp=6", i, lat); end
            n_tests++;
            if (ra !== 1'b1) begin n_fail++; $display("FAIL corner_ready_after[%0d] got=%b exp=1", i, ra); end
            n_tests++;
            if (da !== 1'b0) begin n_fail++; $display("FAIL corner_done_width[%0d] got=%b exp=0", i, da); end
            n_tests++;
            if (b !== cb[i]) begin n_fail++; $display("FAIL corner_b_hold[%0d] got=%h exp=%h", i, b, cb[i]); end
        end
    endtask

    task automatic test_random();
        logic [4:0]  pp;
        logic        vv;
        logic [0:31] bo;
        int          lat;
        logic        ra, da;
        for (int i = 0; i < 20; i++) begin
            pp = 5'($urandom);
            vv = 1'($urandom_range(0, 3) != 0);
            run_op(pp, vv, 1'b1, 1'b0, bo, lat, ra, da);
            n_tests++;
            if (bo !== model(pp, vv) || lat !== 6) begin
                n_fail++;
                $display("FAIL random[%0d] p=%0d v=%b got b=%h lat=%0d exp b=%h lat=6",
                         i, pp, vv, bo, lat, model(pp, vv));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] q [$];
        logic [4:0] pp;
        logic [4:0] ep;
        int         last = -1;
        int         ops  = 0;
        @(negedge clock);
        start = 1'b1;
        for (int cyc = 0; cyc < 45; cyc++) begin
            if (cyc > 0) @(negedge clock);
            if (done === 1'b1) begin
                ops++;
                ep = (q.size() > 0) ? q.pop_front() : 5'd0;
                n_tests++;
                if (b !== model(ep, 1'b1)) begin
                    n_fail++;
                    $display("FAIL b2b_b got=%h exp=%h", b, model(ep, 1'b1));
                end
                if (last >= 0) begin
                    n_tests++;
                    if (cyc - last !== 7) begin
                        n_fail++;
                        $display("FAIL b2b_spacing got=%0d exp=7", cyc - last);
                    end
                end
                last = cyc;
            end
            if (ready === 1'b1) begin
                pp = 5'($urandom);
                p  = pp;
                v  = 1'b1;
                q.push_back(pp);
            end else begin
                p = 5'($urandom);
                v = 1'($urandom);
            end
        end
        start = 1'b0;
        n_tests++;
        if (ops < 5) begin n_fail++; $display("FAIL b2b_ops got=%0d exp>=5", ops); end
        for (int k = 0; k < 20 && ready !== 1'b1; k++) @(negedge clock);
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_return_idle ready got=%b exp=1", ready); end
    endtask

    task automatic test_reset_mid();
        logic [4:0]  pp;
        logic [0:31] bo;
        int          lat;
        int          seen = 0;
        logic        ra, da;
        pp = 5'($urandom);
        @(negedge clock);
        start = 1'b1;
        p     = pp;
        v     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got=%b exp=1", ready); end
        n_tests++;
        if (b !== 32'h0) begin n_fail++; $display("FAIL abort_b got=%h exp=0", b); end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (done === 1'b1) seen++;
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d pulses exp=0", seen); end
        n_tests++;
        if (b !== 32'h0) begin n_fail++; $display("FAIL abort_b_after got=%h exp=0", b); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        pp = 5'($urandom);
        run_op(pp, 1'b1, 1'b1, 1'b1, bo, lat, ra, da);
        n_tests++;
        if (bo !== model(pp, 1'b1) || lat !== 6) begin
            n_fail++;
            $display("FAIL post_reset_op p=%0d got b=%h lat=%0d exp b=%h lat=6", pp, bo, lat, model(pp, 1'b1));
        end
    endtask

    task automatic test_round_trip();
        logic [0:31] bo;
        int          lat;
        logic        ra, da;
        logic [4:0]  rp;
        logic        rv;
        for (int i = 0; i < 32; i++) begin
            run_op(5'(i), 1'b1, 1'b1, 1'b0, bo, lat, ra, da);
            ffo32(bo, rp, rv);
            n_tests++;
            if (rv !== 1'b1 || rp !== 5'(i) || $countones(bo) != 1) begin
                n_fail++;
                $display("FAIL round_trip p=%0d got ffo_p=%0d ffo_v=%b ones=%0d exp p=%0d v=1 ones=1",
                         i, rp, rv, $countones(bo), i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_round_trip();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish, exp completion");
        $fatal(1);
    end

endmodule
